// File: rtl/i2c_tcu_pkg.sv
// Shared types and constants for the TCU I2C controller, its sensor target
// model and their benches.
package i2c_tcu_pkg;

  // Protocol states of the I2C target.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_PTR_ACK  = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD_DATA  = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_IGNORE   = 4'd9
  } i2c_state_t;

  // Register pointer values (pointer byte bits [1:0]).
  localparam logic [1:0] PTR_TEMP  = 2'd0;
  localparam logic [1:0] PTR_CFG   = 2'd1;
  localparam logic [1:0] PTR_TLOW  = 2'd2;
  localparam logic [1:0] PTR_THIGH = 2'd3;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the SCL/SDA pad inputs into the clk domain and derives
// single-cycle SCL edge pulses plus START/STOP condition pulses.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Synchroniser chains plus one delayed copy for edge detection; reset to
  // the idle-high bus level so no event is seen coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl & r_scl_d;
  // SDA edges only count as conditions when SCL was high on both samples.
  assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_temp_sensor_target.sv
// I2C target emulating a P3T1035/P3T2030-style temperature sensor: 7-bit
// address match, pointer + 16-bit register writes, coherent 16-bit reads.
//
// Bus timing: data bits are sampled on synchronised SCL rises; sda_oe only
// changes right after a detected SCL fall, so SDA is stable while SCL is
// high. sda_oe=1 pulls SDA low, sda_oe=0 releases it (open drain).
module i2c_temp_sensor_target
  import i2c_tcu_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDRESS = 7'h70,
  parameter int          SYNC_STAGES    = 2,
  parameter logic [15:0] CFG_RESET      = 16'h0000,
  parameter logic [15:0] TLOW_RESET     = 16'h4B00,
  parameter logic [15:0] THIGH_RESET    = 16'h5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] temp_in,
  output logic [15:0] cfg_reg,
  output logic [15:0] tlow_reg,
  output logic [15:0] thigh_reg,
  output logic        wr_strobe,
  output logic        busy,
  output i2c_state_t  o_dbg_state
);

  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;

  i2c_state_t r_state;
  i2c_state_t w_state_nxt;
  logic       r_sda_oe;
  logic       w_sda_oe_nxt;
  logic       r_busy;
  logic       w_busy_nxt;

  logic [2:0]  r_bit_cnt;    // bits seen in the current byte
  logic        r_full;       // 8 bits seen; act on the following SCL fall
  logic [7:0]  r_shift;      // receive shift register
  logic [1:0]  r_byte_cnt;   // data bytes received in this write
  logic [1:0]  r_ptr;
  logic [7:0]  r_msb;        // staged MSB of a register write
  logic [15:0] r_tx;         // read snapshot, rotated as bits go out
  logic        r_rw;
  logic        r_mack_n;     // master acknowledge bit on reads (0 = ACK)
  logic [15:0] r_cfg;
  logic [15:0] r_tlow;
  logic [15:0] r_thigh;
  logic        r_wr_strobe;
  logic [15:0] w_snap;
  logic        w_addr_match;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_scl     (scl_in),
    .i_sda     (sda_in),
    .o_sda     (w_sda),
    .o_scl_rise(w_scl_rise),
    .o_scl_fall(w_scl_fall),
    .o_start   (w_start),
    .o_stop    (w_stop)
  );

  assign w_addr_match = (r_shift[7:1] == TARGET_ADDRESS);

  // Register selected by the pointer, captured as the read snapshot.
  always_comb begin
    w_snap = temp_in;
    case (r_ptr)
      PTR_CFG:   w_snap = r_cfg;
      PTR_TLOW:  w_snap = r_tlow;
      PTR_THIGH: w_snap = r_thigh;
      default:   w_snap = temp_in;
    endcase
  end

  // State, SDA driver and busy flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Next state and SDA drive: bus conditions override everything, otherwise
  // the protocol advances on SCL falls once a byte or ACK bit has completed.
  always_comb begin
    w_state_nxt  = r_state;
    w_sda_oe_nxt = r_sda_oe;
    w_busy_nxt   = r_busy;
    if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_scl_fall) begin
      case (r_state)
        ST_ADDR: begin
          if (r_full) begin
            if (w_addr_match) begin
              w_state_nxt  = ST_ADDR_ACK;
              w_sda_oe_nxt = 1'b1;
              w_busy_nxt   = 1'b1;
            end else begin
              w_state_nxt  = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (r_rw) begin
            w_state_nxt  = ST_RD_DATA;
            w_sda_oe_nxt = ~r_tx[15];
          end else begin
            w_state_nxt  = ST_PTR;
            w_sda_oe_nxt = 1'b0;
          end
        end
        ST_PTR: begin
          if (r_full) begin
            w_state_nxt  = ST_PTR_ACK;
            w_sda_oe_nxt = 1'b1;
          end
        end
        ST_PTR_ACK: begin
          w_state_nxt  = ST_WR_DATA;
          w_sda_oe_nxt = 1'b0;
        end
        ST_WR_DATA: begin
          if (r_full) begin
            if (r_byte_cnt < 2'd2) begin
              w_state_nxt  = ST_WR_ACK;
              w_sda_oe_nxt = 1'b1;
            end else begin
              // Third and later data bytes: leave SDA released (NACK).
              w_state_nxt  = ST_IGNORE;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        ST_WR_ACK: begin
          w_state_nxt  = ST_WR_DATA;
          w_sda_oe_nxt = 1'b0;
        end
        ST_RD_DATA: begin
          if (r_full) begin
            w_state_nxt  = ST_RD_ACK;
            w_sda_oe_nxt = 1'b0;
          end else begin
            // r_tx rotates on this same fall, so bit 14 is the next bit out.
            w_sda_oe_nxt = ~r_tx[14];
          end
        end
        ST_RD_ACK: begin
          if (!r_mack_n) begin
            w_state_nxt  = ST_RD_DATA;
            w_sda_oe_nxt = ~r_tx[15];
          end else begin
            w_state_nxt  = ST_IGNORE;
            w_sda_oe_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // Datapath: bit/byte counting, pointer, staging, commit and read snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_full      <= 1'b0;
      r_shift     <= 8'd0;
      r_byte_cnt  <= 2'd0;
      r_ptr       <= PTR_TEMP;
      r_msb       <= 8'd0;
      r_tx        <= 16'd0;
      r_rw        <= 1'b0;
      r_mack_n    <= 1'b1;
      r_cfg       <= CFG_RESET;
      r_tlow      <= TLOW_RESET;
      r_thigh     <= THIGH_RESET;
      r_wr_strobe <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_start || w_stop) begin
        r_bit_cnt  <= 3'd0;
        r_full     <= 1'b0;
        r_byte_cnt <= 2'd0;
      end else if (w_scl_rise) begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WR_DATA: begin
            r_shift   <= {r_shift[6:0], w_sda};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_full <= 1'b1;
          end
          ST_RD_DATA: begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_full <= 1'b1;
          end
          ST_RD_ACK: begin
            r_mack_n <= w_sda;
          end
          ST_WR_ACK: begin
            // Second data byte commits on the rise of its ACK bit; the
            // read-only temperature pointer swallows the write.
            if (r_byte_cnt == 2'd1) begin
              case (r_ptr)
                PTR_CFG:   r_cfg   <= {r_msb, r_shift};
                PTR_TLOW:  r_tlow  <= {r_msb, r_shift};
                PTR_THIGH: r_thigh <= {r_msb, r_shift};
                default:   r_cfg   <= r_cfg;
              endcase
              r_wr_strobe <= (r_ptr != PTR_TEMP);
            end
          end
          default: begin
            r_bit_cnt <= r_bit_cnt;
          end
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          ST_ADDR: begin
            if (r_full) begin
              r_rw      <= r_shift[0];
              r_tx      <= w_snap;
              r_bit_cnt <= 3'd0;
              r_full    <= 1'b0;
            end
          end
          ST_PTR: begin
            if (r_full) begin
              r_ptr     <= r_shift[1:0];
              r_bit_cnt <= 3'd0;
              r_full    <= 1'b0;
            end
          end
          ST_WR_DATA: begin
            if (r_full) begin
              if (r_byte_cnt == 2'd0) r_msb <= r_shift;
              r_bit_cnt <= 3'd0;
              r_full    <= 1'b0;
            end
          end
          ST_WR_ACK: begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          ST_RD_DATA: begin
            // Rotate rather than shift so an ACKed LSB wraps to the MSB.
            r_tx <= {r_tx[14:0], r_tx[15]};
            if (r_full) begin
              r_bit_cnt <= 3'd0;
              r_full    <= 1'b0;
            end
          end
          default: begin
            r_bit_cnt <= r_bit_cnt;
          end
        endcase
      end
    end
  end

  assign sda_oe      = r_sda_oe;
  assign busy        = r_busy;
  assign wr_strobe   = r_wr_strobe;
  assign cfg_reg     = r_cfg;
  assign tlow_reg    = r_tlow;
  assign thigh_reg   = r_thigh;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_temp_sensor_target.sv
// Directed bench for i2c_temp_sensor_target: a bit-banged I2C master drives
// the bus and each observation is checked against hand-computed values.
module tb_i2c_temp_sensor_target;
  import i2c_tcu_pkg::*;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        m_sda;
  logic        sda_oe;
  logic        w_sda_bus;
  logic [15:0] temp_in;
  logic [15:0] cfg_reg;
  logic [15:0] tlow_reg;
  logic [15:0] thigh_reg;
  logic        wr_strobe;
  logic        busy;
  i2c_state_t  dbg_state;

  int   n_cmp = 0;
  int   n_err = 0;
  int   strobe_cnt = 0;
  logic watch = 1'b0;
  logic oe_seen = 1'b0;
  logic busy_seen = 1'b0;

  // Wired-AND bus: master open-drain line and the target pull-down.
  assign w_sda_bus = m_sda & ~sda_oe;

  i2c_temp_sensor_target dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_in     (scl),
    .sda_in     (w_sda_bus),
    .sda_oe     (sda_oe),
    .temp_in    (temp_in),
    .cfg_reg    (cfg_reg),
    .tlow_reg   (tlow_reg),
    .thigh_reg  (thigh_reg),
    .wr_strobe  (wr_strobe),
    .busy       (busy),
    .o_dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Event monitors: strobe count and "never driven / never busy" tracking.
  always @(posedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (watch && sda_oe) oe_seen = 1'b1;
    if (watch && busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    wait_q();
    scl = 1'b1;
    wait_q();
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    b = w_sda_bus;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_sda = 1'b0;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_sda = 1'b1;
    wait_q();
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack_n);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic m_ack);
    logic b;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(m_ack ? 1'b0 : 1'b1);
  endtask

  // Directed stimulus sequence.
  initial begin
    logic       ack_n;
    logic [7:0] d;
    int         s0;

    rst_n   = 1'b0;
    scl     = 1'b1;
    m_sda   = 1'b1;
    temp_in = 16'h1A30;
    repeat (4) @(negedge clk);
    check("rst_sda_oe", {15'd0, sda_oe}, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'h0000);
    check("rst_wr_strobe", {15'd0, wr_strobe}, 16'h0000);
    check("rst_state", {12'd0, dbg_state}, {12'd0, ST_IDLE});
    check("rst_cfg", cfg_reg, 16'h0000);
    check("rst_tlow", tlow_reg, 16'h4B00);
    check("rst_thigh", thigh_reg, 16'h5000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Pointer 0 then repeated-START read of temperature.
    i2c_start();
    write_byte(8'hE0, ack_n);
    check("t1_addr_w_ack", {15'd0, ack_n}, 16'h0000);
    write_byte(8'h00, ack_n);
    check("t1_ptr_ack", {15'd0, ack_n}, 16'h0000);
    i2c_start();
    write_byte(8'hE1, ack_n);
    check("t1_addr_r_ack", {15'd0, ack_n}, 16'h0000);
    check("t1_busy", {15'd0, busy}, 16'h0001);
    read_byte(d, 1'b1);
    check("t1_msb", {8'd0, d}, 16'h001A);
    read_byte(d, 1'b0);
    check("t1_lsb", {8'd0, d}, 16'h0030);
    i2c_stop();
    check("t1_oe_after_stop", {15'd0, sda_oe}, 16'h0000);
    check("t1_busy_after_stop", {15'd0, busy}, 16'h0000);
    check("t1_state_idle", {12'd0, dbg_state}, {12'd0, ST_IDLE});

    // Full T_LOW write, then an extra byte that must be NACKed.
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hE0, ack_n);
    write_byte(8'h02, ack_n);
    write_byte(8'h55, ack_n);
    check("t2_b1_ack", {15'd0, ack_n}, 16'h0000);
    write_byte(8'hAA, ack_n);
    check("t2_b2_ack", {15'd0, ack_n}, 16'h0000);
    check("t2_tlow", tlow_reg, 16'h55AA);
    check("t2_strobes", 16'(strobe_cnt - s0), 16'd1);
    write_byte(8'h77, ack_n);
    check("t2_b3_nack", {15'd0, ack_n}, 16'h0001);
    i2c_stop();
    check("t2_tlow_kept", tlow_reg, 16'h55AA);
    check("t2_strobes_kept", 16'(strobe_cnt - s0), 16'd1);

    // Foreign address: never ACK, never drive, never busy.
    watch = 1'b1;
    i2c_start();
    write_byte(8'h90, ack_n);
    check("t3_addr_nack", {15'd0, ack_n}, 16'h0001);
    write_byte(8'h01, ack_n);
    i2c_stop();
    watch = 1'b0;
    check("t3_oe_never", {15'd0, oe_seen}, 16'h0000);
    check("t3_busy_never", {15'd0, busy_seen}, 16'h0000);

    // Coherent snapshot while temp_in changes between bytes.
    i2c_start();
    write_byte(8'hE0, ack_n);
    write_byte(8'h00, ack_n);
    i2c_start();
    write_byte(8'hE1, ack_n);
    read_byte(d, 1'b1);
    check("t4_msb", {8'd0, d}, 16'h001A);
    temp_in = 16'h2B40;
    read_byte(d, 1'b0);
    check("t4_lsb", {8'd0, d}, 16'h0030);
    i2c_stop();

    // Incomplete write leaves CFG untouched.
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hE0, ack_n);
    write_byte(8'h01, ack_n);
    write_byte(8'h12, ack_n);
    i2c_stop();
    check("t5_cfg_kept", cfg_reg, 16'h0000);
    check("t5_no_strobe", 16'(strobe_cnt - s0), 16'd0);

    // Reset in the middle of a read of CFG (first bit 0 -> SDA pulled low).
    i2c_start();
    write_byte(8'hE1, ack_n);
    check("t5_rd_driving", {15'd0, sda_oe}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("t5_async_release", {15'd0, sda_oe}, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_tlow_reset", tlow_reg, 16'h4B00);
    i2c_stop();

    // T_HIGH read with wrap across ACKed bytes.
    i2c_start();
    write_byte(8'hE0, ack_n);
    write_byte(8'h03, ack_n);
    i2c_start();
    write_byte(8'hE1, ack_n);
    read_byte(d, 1'b1);
    check("t6_byte0", {8'd0, d}, 16'h0050);
    read_byte(d, 1'b1);
    check("t6_byte1", {8'd0, d}, 16'h0000);
    read_byte(d, 1'b1);
    check("t6_byte2", {8'd0, d}, 16'h0050);
    read_byte(d, 1'b1);
    check("t6_byte3", {8'd0, d}, 16'h0000);
    read_byte(d, 1'b0);
    check("t6_byte4", {8'd0, d}, 16'h0050);
    i2c_stop();
    check("t6_busy_after_stop", {15'd0, busy}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
